// File: rtl/icache_dm_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM encoding and
// address-field width derivation.
package icache_dm_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FILL = 2'd2
  } state_t;

  function automatic int off_bits(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int idx_bits(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_bits(input int line_words, input int num_lines);
    return 32 - idx_bits(num_lines) - off_bits(line_words);
  endfunction

endpackage

// File: rtl/icache_dm_store.sv
// Tag, valid and data storage for the direct-mapped instruction cache.
// Combinational read port, one write port, and a flush-all of the valid vector.
module icache_store
  import icache_dm_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 64,
  localparam int OFF_W  = off_bits(LINE_WORDS),
  localparam int IDX_W  = idx_bits(NUM_LINES),
  localparam int TAG_W  = tag_bits(LINE_WORDS, NUM_LINES),
  localparam int WORD_W = OFF_W - 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_all,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [WORD_W-1:0] rd_word,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid,
  output logic [31:0]       rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_word,
  input  logic [31:0]       wr_data,
  input  logic              line_done,
  input  logic [TAG_W-1:0]  line_tag
);

  logic [TAG_W-1:0]     tag_ram  [NUM_LINES];
  logic [31:0]          data_ram [NUM_LINES*LINE_WORDS];
  logic [NUM_LINES-1:0] valid;

  assign rd_tag   = tag_ram[rd_idx];
  assign rd_valid = valid[rd_idx];
  assign rd_data  = data_ram[{rd_idx, rd_word}];

  // A flush landing on the same edge as a line completion wins, so that line stays invalid
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (flush_all) begin
      valid <= '0;
    end else if (line_done) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_ram[{wr_idx, wr_word}] <= wr_data;
    end
    if (line_done) begin
      tag_ram[wr_idx] <= line_tag;
    end
  end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped L1 instruction cache: 1-cycle hits, pipeline freeze on miss,
// and whole-line refill over a request/grant + beat-valid memory bus.
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [31:0] cpu_pc,
  input  logic        flush,
  output logic [31:0] cpu_inst,
  output logic        cpu_valid,
  output logic        waiting,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int OFF_W  = off_bits(LINE_WORDS);
  localparam int IDX_W  = idx_bits(NUM_LINES);
  localparam int TAG_W  = tag_bits(LINE_WORDS, NUM_LINES);
  localparam int WORD_W = OFF_W - 2;

  state_t state, state_nx;

  logic [TAG_W+IDX_W-1:0] miss_q;
  logic [WORD_W-1:0]      beat_cnt;
  logic                   flush_pend;

  logic [TAG_W-1:0]  pc_tag;
  logic [IDX_W-1:0]  pc_idx;
  logic [WORD_W-1:0] pc_word;
  logic              pc_unused;
  logic [TAG_W-1:0]  st_tag;
  logic              st_valid;
  logic [31:0]       st_data;
  logic              hit;
  logic              last_beat;
  logic              flush_all;
  logic              fill_wr;

  assign pc_tag    = cpu_pc[31 -: TAG_W];
  assign pc_idx    = cpu_pc[OFF_W +: IDX_W];
  assign pc_word   = cpu_pc[OFF_W-1:2];
  assign pc_unused = ^cpu_pc[1:0];

  // A flush in the lookup cycle must not return a line it is about to invalidate
  assign hit       = st_valid && (st_tag == pc_tag) && !flush;
  assign fill_wr   = (state == S_FILL) && mem_rvalid && !rst;
  assign last_beat = fill_wr && (beat_cnt == WORD_W'(LINE_WORDS - 1));
  assign flush_all = ((state == S_IDLE) && flush) || (last_beat && (flush_pend || flush));

  assign waiting  = (state != S_IDLE) || (cpu_req && !hit);
  assign mem_req  = (state == S_REQ);
  assign mem_addr = {miss_q, {OFF_W{1'b0}}};

  icache_store #(
    .LINE_WORDS(LINE_WORDS),
    .NUM_LINES (NUM_LINES)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .flush_all(flush_all),
    .rd_idx   (pc_idx),
    .rd_word  (pc_word),
    .rd_tag   (st_tag),
    .rd_valid (st_valid),
    .rd_data  (st_data),
    .wr_en    (fill_wr),
    .wr_idx   (miss_q[IDX_W-1:0]),
    .wr_word  (beat_cnt),
    .wr_data  (mem_rdata),
    .line_done(last_beat),
    .line_tag (miss_q[TAG_W+IDX_W-1:IDX_W])
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (cpu_req && !hit) state_nx = S_REQ;
      S_REQ:   if (mem_gnt) state_nx = S_FILL;
      S_FILL:  if (last_beat) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      miss_q     <= '0;
      beat_cnt   <= '0;
      flush_pend <= 1'b0;
      cpu_inst   <= '0;
      cpu_valid  <= 1'b0;
    end else begin
      state     <= state_nx;
      cpu_valid <= (state == S_IDLE) && cpu_req && hit;
      if ((state == S_IDLE) && cpu_req && hit) begin
        cpu_inst <= st_data;
      end
      if ((state == S_IDLE) && cpu_req && !hit) begin
        miss_q <= cpu_pc[31:OFF_W];
      end
      if ((state == S_REQ) && mem_gnt) begin
        beat_cnt <= '0;
      end else if (fill_wr) begin
        beat_cnt <= beat_cnt + WORD_W'(1);
      end
      // Flushes seen mid-refill are held until the line completes
      if (last_beat) begin
        flush_pend <= 1'b0;
      end else if ((state != S_IDLE) && flush) begin
        flush_pend <= 1'b1;
      end
    end
  end

endmodule
